video_modulator_mult_array: RTL
===============================

VIDEO_MODULATOR_MULT_ARRAY -- requirements
Module: video_modulator_mult_array

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2: number of independent multiplier lanes (1..8).
REQ-002 The block SHALL have parameter A_WIDTH, default 8: width of each lane's A operand (2..18).
REQ-003 The block SHALL have parameter B_WIDTH, default 8: width of each lane's B operand (2..18).
REQ-004 The block SHALL have parameter OUT_WIDTH, default 16: width of each lane result (2..A_WIDTH+B_WIDTH).
REQ-005 The block SHALL have parameter SHIFT, default 0: right shift applied to the product (0..A_WIDTH+B_WIDTH-1).
REQ-006 The block SHALL have parameter PIPE_STAGES, default 2: input-to-output latency in enabled cycles (2..4).
REQ-007 The block SHALL have these ports (clock and reset first):
- clk  in  1  clock; one clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  clock enable; low stalls entire pipeline.
- clear  in  1  synchronous flush of valid pipeline and overflow flags.
- in_valid  in  1  lane operands valid this cycle.
- in_signed  in  CHANNELS  per-lane mode; 1 = two's-complement, 0 = unsigned.
- in_a  in  CHANNELS*A_WIDTH  packed A operands; lane 0 in LSBs.
- in_b  in  CHANNELS*B_WIDTH  packed B operands; lane 0 in LSBs.
- out_valid  out  1  result valid.
- out_data  out  CHANNELS*OUT_WIDTH  packed results; lane 0 in LSBs.
- out_ovf  out  CHANNELS  sticky per-lane saturation flags.

Function
REQ-008 Each lane SHALL form P = A*B at width A_WIDTH+B_WIDTH, sign-extending operands when the lane's in_signed bit is 1, zero-extending when 0.
REQ-009 When SHIFT>0, each lane SHALL compute R = (P + 2^(SHIFT-1)) >> SHIFT, arithmetic shift in signed mode and logical in unsigned, with the add one bit wider than P so it cannot wrap; when SHIFT=0, R = P.
REQ-010 Each lane SHALL saturate R to OUT_WIDTH: unsigned mode to 0..2^OUT_WIDTH-1; signed mode to -2^(OUT_WIDTH-1)..2^(OUT_WIDTH-1)-1.
REQ-011 The block SHALL capture in_valid, in_signed, in_a and in_b only in cycles where enable=1.
REQ-012 A sample captured in enabled cycle N SHALL appear on out_data with out_valid=1 after exactly PIPE_STAGES enabled cycles.
REQ-013 Cycles with enable=0 SHALL freeze all pipeline state, out_valid, out_data and out_ovf.
REQ-014 out_data SHALL update only when a valid sample reaches the output stage and SHALL hold its last value otherwise.
REQ-015 out_valid SHALL be 1 for exactly one enabled cycle per valid input sample. Back-to-back valid inputs SHALL yield back-to-back valid outputs at full throughput.
REQ-016 A lane's out_ovf bit SHALL set in the same cycle its saturated result is presented with out_valid=1. The bit SHALL remain set until clear or reset.
REQ-017 clear=1 SHALL zero all in-flight valid bits and out_valid, and clear out_ovf, on the next rising edge regardless of enable. out_data SHALL be left unchanged.
REQ-018 When clear and in_valid are both 1, the incoming sample SHALL be discarded.
REQ-019 Lanes SHALL be fully independent; a mode or saturation event in one lane SHALL not affect any other lane.

Reset
REQ-020 While rst_n=0, out_valid, out_data, out_ovf and all pipeline registers SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight samples. The first post-reset output SHALL come from a sample captured after rst_n rises.

Verification
REQ-022 Defaults: unsigned lane0 A=255,B=255, lane1 A=3,B=7, one valid cycle -> two enabled cycles later out_data={16'd21,16'hFE01}, out_valid pulse of 1 cycle, out_ovf=0.
REQ-023 A_WIDTH=B_WIDTH=8, OUT_WIDTH=8, SHIFT=4:
- lane0 unsigned 200*200 -> 8'hFF, out_ovf[0]=1.
- lane1 signed -100*100 -> 8'h80, out_ovf[1]=1.
- Next sample lane0 unsigned 16*16 -> 8'h10, out_ovf[0] stays 1.
REQ-024 Stall: valid samples S0,S1,S2 on consecutive enabled cycles, enable=0 for 3 cycles between S1 and S2 -> outputs in order S0,S1,S2, each valid once, with no change during the stall.
REQ-025 Flush: clear=1 while two samples are in flight -> no out_valid for those samples, out_ovf=0. A sample issued the cycle after clear emerges normally.
REQ-026 PIPE_STAGES=4: continuous valid stream for 10 cycles -> first out_valid 4 cycles after first input, then 10 consecutive valid outputs matching a reference model.
REQ-027 Reset: rst_n pulsed low asynchronously (between clock edges) with samples in flight -> all outputs 0 immediately, and no stale out_valid after release.

Source files
------------

// File: rtl/video_modulator_mult_array.sv
// Multi-lane multiplier with rounding right-shift and saturation.
// Latency is PIPE_STAGES enabled cycles; out_data holds between valid results.

module video_modulator_mult_lane #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                 sgn,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic [OUT_WIDTH-1:0] res,
  output logic                 ovf
);
  localparam int PW = A_WIDTH + B_WIDTH;

  logic [PW-1:0] ax, bx, p;
  logic [PW:0]   pe, r;

  always_comb begin
    ax = sgn ? {{B_WIDTH{a[A_WIDTH-1]}}, a} : {{B_WIDTH{1'b0}}, a};
    bx = sgn ? {{A_WIDTH{b[B_WIDTH-1]}}, b} : {{A_WIDTH{1'b0}}, b};
    p  = ax * bx;
    // one extra bit so the rounding add cannot wrap
    pe = {sgn & p[PW-1], p};
  end

  generate
    if (SHIFT == 0) begin : g_noshift
      assign r = pe;
    end else begin : g_shift
      localparam logic [PW:0] RND = (PW+1)'(1) << (SHIFT - 1);
      logic        [PW:0] sum;
      logic signed [PW:0] rs;
      assign sum = pe + RND;
      assign rs  = $signed(sum) >>> SHIFT;
      assign r   = sgn ? $unsigned(rs) : (sum >> SHIFT);
    end
  endgenerate

  always_comb begin
    if (sgn) begin
      // in range iff all bits above the output sign bit match it
      ovf = ~((&r[PW:OUT_WIDTH-1]) | ~(|r[PW:OUT_WIDTH-1]));
      res = ovf ? {r[PW], {(OUT_WIDTH-1){~r[PW]}}} : r[OUT_WIDTH-1:0];
    end else begin
      ovf = |r[PW:OUT_WIDTH];
      res = ovf ? '1 : r[OUT_WIDTH-1:0];
    end
  end
endmodule

module video_modulator_mult_array #(
  parameter int CHANNELS    = 2,
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 0,
  parameter int PIPE_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [CHANNELS-1:0]           in_signed,
  input  logic [CHANNELS*A_WIDTH-1:0]   in_a,
  input  logic [CHANNELS*B_WIDTH-1:0]   in_b,
  output logic                          out_valid,
  output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]           out_ovf
);
  localparam int NM = PIPE_STAGES - 2;

  logic [CHANNELS-1:0][A_WIDTH-1:0]   a_q;
  logic [CHANNELS-1:0][B_WIDTH-1:0]   b_q;
  logic [CHANNELS-1:0]                sgn_q;
  logic [PIPE_STAGES-1:0]             vld_pipe;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0] res, res_last, data_q;
  logic [CHANNELS-1:0]                ovf, ovf_last, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= '0;
    end else if (enable) begin
      a_q   <= in_a;
      b_q   <= in_b;
      sgn_q <= in_signed;
    end
  end

  // clear drops in-flight samples (and the incoming one) even when stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vld_pipe <= '0;
    else if (clear)  vld_pipe <= '0;
    else if (enable) vld_pipe <= {vld_pipe[PIPE_STAGES-2:0], in_valid};
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      video_modulator_mult_lane #(
        .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
      ) u_lane (
        .sgn(sgn_q[c]), .a(a_q[c]), .b(b_q[c]), .res(res[c]), .ovf(ovf[c])
      );
    end

    if (NM == 0) begin : g_nomid
      assign res_last = res;
      assign ovf_last = ovf;
    end else begin : g_mid
      logic [CHANNELS-1:0][OUT_WIDTH-1:0] dp [NM];
      logic [CHANNELS-1:0]                op [NM];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NM; i++) begin
            dp[i] <= '0;
            op[i] <= '0;
          end
        end else if (enable) begin
          dp[0] <= res;
          op[0] <= ovf;
          for (int i = 1; i < NM; i++) begin
            dp[i] <= dp[i-1];
            op[i] <= op[i-1];
          end
        end
      end
      assign res_last = dp[NM-1];
      assign ovf_last = op[NM-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= '0;
    end else if (clear) begin
      ovf_q  <= '0;
    end else if (enable && vld_pipe[PIPE_STAGES-2]) begin
      data_q <= res_last;
      ovf_q  <= ovf_q | ovf_last;
    end
  end

  assign out_valid = vld_pipe[PIPE_STAGES-1];
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;
endmodule
